// File: rtl/instr_encoder_pkg.sv
// Shared RV32I encoder definitions: request classes, opcodes, branch funct3 codes
// and immediate formats, matching the constants used by the core's decoder.
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    K_LW   = 3'd0,
    K_SW   = 3'd1,
    K_RT   = 3'd2,
    K_BT   = 3'd3,
    K_IT   = 3'd4,
    K_LUI  = 3'd5,
    K_JAL  = 3'd6,
    K_JALR = 3'd7
  } kind_e;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } imm_fmt_e;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RT   = 7'b0110011;
  localparam logic [6:0] OP_BT   = 7'b1100011;
  localparam logic [6:0] OP_IT   = 7'b0010011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;

  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b000;
  localparam logic [2:0] F3_SLLI = 3'b001;
  localparam logic [2:0] F3_SRXI = 3'b101;

  function automatic imm_fmt_e fmt_of(input kind_e k);
    case (k)
      K_LW, K_IT, K_JALR: return FMT_I;
      K_SW:               return FMT_S;
      K_BT:               return FMT_B;
      K_LUI:              return FMT_U;
      K_JAL:              return FMT_J;
      default:            return FMT_R;
    endcase
  endfunction

  function automatic logic [6:0] opcode_of(input kind_e k);
    case (k)
      K_LW:    return OP_LW;
      K_SW:    return OP_SW;
      K_RT:    return OP_RT;
      K_BT:    return OP_BT;
      K_IT:    return OP_IT;
      K_LUI:   return OP_LUI;
      K_JAL:   return OP_JAL;
      default: return OP_JALR;
    endcase
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request bus (field-level instruction requests) and instruction-memory write bus.
interface instr_req_if;
  import instr_encoder_pkg::*;

  logic        in_valid;
  logic        in_ready;
  kind_e       in_kind;
  logic [2:0]  in_f3;
  logic        in_f7b5;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;

  modport master (output in_valid, in_kind, in_f3, in_f7b5, in_rd, in_rs1, in_rs2, in_imm,
                  input  in_ready);
  modport slave  (input  in_valid, in_kind, in_f3, in_f7b5, in_rd, in_rs1, in_rs2, in_imm,
                  output in_ready);
endinterface

interface instr_mem_if #(parameter int ADDR_W = 32);
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;

  modport master (output mem_we, mem_addr, mem_wdata, input mem_ready);
  modport slave  (input  mem_we, mem_addr, mem_wdata, output mem_ready);
endinterface

// File: rtl/instr_encoder_pack.sv
// Combinational field packer: turns one request into an RV32I word and flags
// requests whose immediate or funct3 cannot be represented.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  kind_e       kind,
  input  logic [2:0]  f3,
  input  logic        f7b5,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  logic signed [31:0] imm_s;
  imm_fmt_e           fmt;
  logic [6:0]         op;
  logic [2:0]         f3_eff;
  logic [11:0]        imm12;
  logic               is_shift;
  logic               fits12;

  assign imm_s = imm;

  always_comb begin
    fmt      = fmt_of(kind);
    op       = opcode_of(kind);
    is_shift = (kind == K_IT) && ((f3 == F3_SLLI) || (f3 == F3_SRXI));
    fits12   = (imm_s >= -2048) && (imm_s <= 2047);

    case (kind)
      K_LW, K_SW: f3_eff = F3_WORD;
      K_JALR:     f3_eff = F3_JALR;
      default:    f3_eff = f3;
    endcase

    // Shift-immediates reuse the imm[11:5] slot as a funct7 carrying the sra bit
    imm12 = is_shift ? {1'b0, f7b5, 5'b00000, imm[4:0]} : imm[11:0];

    word    = '0;
    illegal = 1'b0;
    case (fmt)
      FMT_R: begin
        word = {1'b0, f7b5, 5'b00000, rs2, rs1, f3_eff, rd, op};
      end
      FMT_I: begin
        word    = {imm12, rs1, f3_eff, rd, op};
        illegal = is_shift ? !((imm_s >= 0) && (imm_s <= 31)) : !fits12;
      end
      FMT_S: begin
        word    = {imm[11:5], rs2, rs1, f3_eff, imm[4:0], op};
        illegal = !fits12;
      end
      FMT_B: begin
        word    = {imm[12], imm[10:5], rs2, rs1, f3_eff, imm[4:1], imm[11], op};
        illegal = !((imm_s >= -4096) && (imm_s <= 4094)) || imm[0] ||
                  !(f3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE});
      end
      FMT_U: begin
        word    = {imm[31:12], rd, op};
        illegal = |imm[11:0];
      end
      FMT_J: begin
        word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        illegal = !((imm_s >= -(32'sd1 <<< 20)) && (imm_s <= (32'sd1 <<< 20) - 2)) || imm[0];
      end
      default: begin
        word    = '0;
        illegal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: accepts field requests, packs them and writes the
// words to instruction memory at consecutive byte addresses.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic        clk,
  input  logic        rst,
  instr_req_if.slave  req,
  instr_mem_if.master mem,
  output logic        err,
  output logic [15:0] word_count,
  output logic [7:0]  err_count
);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [31:0]       word_p0;
  logic              illegal_p0;
  logic              accept_p0;
  logic              vld_p1;
  logic [31:0]       wdata_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic              err_p1;
  logic              done_p1;

  instr_pack u_pack (
    .kind    (req.in_kind),
    .f3      (req.in_f3),
    .f7b5    (req.in_f7b5),
    .rd      (req.in_rd),
    .rs1     (req.in_rs1),
    .rs2     (req.in_rs2),
    .imm     (req.in_imm),
    .word    (word_p0),
    .illegal (illegal_p0)
  );

  // The output register may refill in the same cycle its current word drains
  assign done_p1      = vld_p1 && mem.mem_ready;
  assign req.in_ready = !vld_p1 || mem.mem_ready;
  assign accept_p0    = req.in_valid && req.in_ready;

  // ---- stage p0 -> p1: output register, address and counters ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      wdata_p1   <= '0;
      addr_p1    <= BASE_ADDR;
      err_p1     <= 1'b0;
      word_count <= '0;
      err_count  <= '0;
    end else begin
      if (done_p1) begin
        addr_p1    <= addr_p1 + ADDR_W'(4);
        word_count <= word_count + 16'd1;
      end
      if (accept_p0 && !illegal_p0) begin
        vld_p1   <= 1'b1;
        wdata_p1 <= word_p0;
      end else if (done_p1) begin
        vld_p1 <= 1'b0;
      end
      err_p1 <= accept_p0 && illegal_p0;
      if (accept_p0 && illegal_p0) begin
        err_count <= sat_inc8(err_count);
      end
    end
  end

  assign mem.mem_we    = vld_p1;
  assign mem.mem_addr  = addr_p1;
  assign mem.mem_wdata = wdata_p1;
  assign err           = err_p1;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus a randomized
// run scored against a field-arithmetic model of the RV32I encodings.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        err;
  logic [15:0] word_count;
  logic [7:0]  err_count;
  int          checks = 0;
  int          errors = 0;

  instr_req_if                 req ();
  instr_mem_if #(.ADDR_W(32))  mem ();

  instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .mem        (mem),
    .err        (err),
    .word_count (word_count),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input int f3, input int f7b5, input int rd,
                       input int rs1, input int rs2, input int imm);
    logic [31:0] v;
    req.in_valid = 1'b1;
    req.in_kind  = kind_e'(3'(k));
    req.in_f3    = 3'(f3);
    req.in_f7b5  = 1'(f7b5);
    req.in_rd    = 5'(rd);
    req.in_rs1   = 5'(rs1);
    req.in_rs2   = 5'(rs2);
    v            = imm;
    req.in_imm   = v;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    req.in_valid  = 1'b0;
    mem.mem_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    req.in_valid  = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic bit [31:0] ienc(input bit [31:0] imm, input bit [31:0] rs1,
                                     input bit [31:0] f3, input bit [31:0] rd,
                                     input bit [31:0] op);
    return ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
  endfunction

  // Reference encoder: fields placed with shifts and masks, legality from integer ranges
  task automatic model(input bit [31:0] k, input bit [31:0] f3, input bit [31:0] f7b5,
                       input bit [31:0] rd, input bit [31:0] rs1, input bit [31:0] rs2,
                       input int imm, output bit [31:0] w, output bit bad);
    bit [31:0] u;
    u   = imm;
    bad = 1'b0;
    w   = '0;
    case (k)
      0: begin bad = imm < -2048 || imm > 2047; w = ienc(u, rs1, 2, rd, 3); end
      1: begin
        bad = imm < -2048 || imm > 2047;
        w = (((u >> 5) & 127) << 25) | (rs2 << 20) | (rs1 << 15) | (32'd2 << 12) |
            ((u & 31) << 7) | 32'd35;
      end
      2: w = (f7b5 << 30) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'd51;
      3: begin
        bad = imm < -4096 || imm > 4094 || u[0] || !(f3 inside {0, 1, 4, 5});
        w = (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | (rs2 << 20) | (rs1 << 15) |
            (f3 << 12) | (((u >> 1) & 15) << 8) | (((u >> 11) & 1) << 7) | 32'd99;
      end
      4: begin
        if (f3 == 1 || f3 == 5) begin
          bad = imm < 0 || imm > 31;
          w = ienc((f7b5 << 10) | (u & 31), rs1, f3, rd, 19);
        end else begin
          bad = imm < -2048 || imm > 2047;
          w = ienc(u, rs1, f3, rd, 19);
        end
      end
      5: begin bad = (u & 32'hFFF) != 0; w = (u & 32'hFFFFF000) | (rd << 7) | 32'd55; end
      6: begin
        bad = imm < -(1 << 20) || imm > (1 << 20) - 2 || u[0];
        w = (((u >> 20) & 1) << 31) | (((u >> 1) & 1023) << 21) | (((u >> 11) & 1) << 20) |
            (((u >> 12) & 255) << 12) | (rd << 7) | 32'd111;
      end
      default: begin bad = imm < -2048 || imm > 2047; w = ienc(u, rs1, 0, rd, 103); end
    endcase
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (req.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", req.in_ready); end
    checks++; if (mem.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%b exp=0", mem.mem_we); end
    checks++; if (mem.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got=%h exp=0", mem.mem_addr); end
    checks++; if (mem.mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata got=%h exp=0", mem.mem_wdata); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (word_count !== 16'd0) begin errors++; $display("FAIL reset_word_count got=%0d exp=0", word_count); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
  endtask

  task automatic test_addi();
    do_reset();
    drive(4, 0, 0, 1, 0, 0, 5);
    step();
    req.in_valid = 1'b0;
    checks++; if (mem.mem_we !== 1'b1) begin errors++; $display("FAIL addi_we got=%b exp=1", mem.mem_we); end
    checks++; if (mem.mem_addr !== 32'h0) begin errors++; $display("FAIL addi_addr got=%h exp=0", mem.mem_addr); end
    checks++; if (mem.mem_wdata !== 32'h00500093) begin errors++; $display("FAIL addi_word got=%h exp=00500093", mem.mem_wdata); end
    step();
    checks++; if (word_count !== 16'd1) begin errors++; $display("FAIL addi_count got=%0d exp=1", word_count); end
    checks++; if (mem.mem_we !== 1'b0) begin errors++; $display("FAIL addi_we_drop got=%b exp=0", mem.mem_we); end
    checks++; if (mem.mem_addr !== 32'h4) begin errors++; $display("FAIL addi_addr_next got=%h exp=4", mem.mem_addr); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1, 0, 0, 0, 1, 2, 8);
    step();
    drive(3, 0, 0, 0, 1, 2, -4);
    checks++; if (mem.mem_we !== 1'b1 || mem.mem_addr !== 32'h0 || mem.mem_wdata !== 32'h0020A423) begin
      errors++; $display("FAIL b2b_sw got we=%b addr=%h word=%h exp we=1 addr=0 word=0020A423", mem.mem_we, mem.mem_addr, mem.mem_wdata); end
    step();
    req.in_valid = 1'b0;
    checks++; if (mem.mem_we !== 1'b1 || mem.mem_addr !== 32'h4 || mem.mem_wdata !== 32'hFE208EE3) begin
      errors++; $display("FAIL b2b_beq got we=%b addr=%h word=%h exp we=1 addr=4 word=FE208EE3", mem.mem_we, mem.mem_addr, mem.mem_wdata); end
    step();
    checks++; if (mem.mem_we !== 1'b0 || word_count !== 16'd2) begin
      errors++; $display("FAIL b2b_end got we=%b count=%0d exp we=0 count=2", mem.mem_we, word_count); end
  endtask

  task automatic test_jal_lui();
    do_reset();
    drive(6, 0, 0, 1, 0, 0, 2048);
    step();
    drive(5, 0, 0, 5, 0, 0, 32'h12345000);
    checks++; if (mem.mem_wdata !== 32'h001000EF) begin errors++; $display("FAIL jal_word got=%h exp=001000EF", mem.mem_wdata); end
    step();
    req.in_valid = 1'b0;
    checks++; if (mem.mem_wdata !== 32'h123452B7 || mem.mem_addr !== 32'h4) begin
      errors++; $display("FAIL lui_word got word=%h addr=%h exp word=123452B7 addr=4", mem.mem_wdata, mem.mem_addr); end
    step();
  endtask

  task automatic test_stall();
    do_reset();
    mem.mem_ready = 1'b0;
    drive(4, 0, 0, 1, 0, 0, 5);
    step();
    drive(4, 0, 0, 2, 1, 0, -1);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (req.in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d] got=%b exp=0", i, req.in_ready); end
      step();
      checks++; if (mem.mem_we !== 1'b1 || mem.mem_addr !== 32'h0 || mem.mem_wdata !== 32'h00500093 || word_count !== 16'd0) begin
        errors++; $display("FAIL stall_hold[%0d] got we=%b addr=%h word=%h count=%0d exp we=1 addr=0 word=00500093 count=0",
                           i, mem.mem_we, mem.mem_addr, mem.mem_wdata, word_count); end
    end
    mem.mem_ready = 1'b1;
    #1;
    checks++; if (req.in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got=%b exp=1", req.in_ready); end
    step();
    req.in_valid = 1'b0;
    checks++; if (mem.mem_addr !== 32'h4 || mem.mem_wdata !== 32'hFFF08113 || word_count !== 16'd1) begin
      errors++; $display("FAIL stall_next got addr=%h word=%h count=%0d exp addr=4 word=FFF08113 count=1", mem.mem_addr, mem.mem_wdata, word_count); end
    step();
    checks++; if (mem.mem_we !== 1'b0 || word_count !== 16'd2) begin
      errors++; $display("FAIL stall_end got we=%b count=%0d exp we=0 count=2", mem.mem_we, word_count); end
  endtask

  task automatic test_illegal();
    do_reset();
    drive(4, 0, 0, 1, 0, 0, 4096);
    step();
    drive(3, 0, 0, 0, 1, 2, 3);
    checks++; if (err !== 1'b1 || mem.mem_we !== 1'b0) begin
      errors++; $display("FAIL illegal_it got err=%b we=%b exp err=1 we=0", err, mem.mem_we); end
    step();
    req.in_valid = 1'b0;
    checks++; if (err !== 1'b1 || err_count !== 8'd2) begin
      errors++; $display("FAIL illegal_bt got err=%b count=%0d exp err=1 count=2", err, err_count); end
    step();
    checks++; if (err !== 1'b0 || mem.mem_we !== 1'b0 || mem.mem_addr !== 32'h0 || err_count !== 8'd2) begin
      errors++; $display("FAIL illegal_after got err=%b we=%b addr=%h count=%0d exp 0 0 0 2", err, mem.mem_we, mem.mem_addr, err_count); end
  endtask

  task automatic test_err_saturate();
    do_reset();
    drive(6, 0, 0, 1, 0, 0, 3);
    repeat (260) step();
    req.in_valid = 1'b0;
    step();
    checks++; if (err_count !== 8'd255 || word_count !== 16'd0 || mem.mem_we !== 1'b0) begin
      errors++; $display("FAIL err_saturate got errs=%0d words=%0d we=%b exp 255 0 0", err_count, word_count, mem.mem_we); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(4, 0, 0, 1, 0, 0, 5);
    step();
    req.in_valid = 1'b0;
    step();
    mem.mem_ready = 1'b0;
    drive(7, 0, 0, 1, 2, 0, 16);
    step();
    req.in_valid = 1'b0;
    checks++; if (mem.mem_we !== 1'b1 || mem.mem_addr !== 32'h4) begin
      errors++; $display("FAIL rstmid_pre got we=%b addr=%h exp we=1 addr=4", mem.mem_we, mem.mem_addr); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    mem.mem_ready = 1'b1;
    checks++; if (mem.mem_we !== 1'b0 || mem.mem_addr !== 32'h0 || word_count !== 16'd0 || mem.mem_wdata !== 32'h0) begin
      errors++; $display("FAIL rstmid got we=%b addr=%h count=%0d word=%h exp 0 0 0 0", mem.mem_we, mem.mem_addr, word_count, mem.mem_wdata); end
  endtask

  task automatic test_random();
    bit [31:0] q[$];
    bit [31:0] exp_addr = 0;
    int        exp_wc = 0;
    int        exp_ec = 0;
    bit        prev_bad = 0;
    bit        acc = 0;
    bit        done;
    int        rk, rf3, rf7, rrd, rrs1, rrs2, rimm;
    bit [31:0] w, got;
    bit        bad;
    do_reset();
    for (int c = 0; c < 700; c++) begin
      if (c >= 680) begin
        req.in_valid  = 1'b0;
        mem.mem_ready = 1'b1;
      end else begin
        if (!req.in_valid || acc) begin
          rk = $urandom_range(0, 7); rf3 = $urandom_range(0, 7); rf7 = $urandom_range(0, 1);
          rrd = $urandom_range(0, 31); rrs1 = $urandom_range(0, 31); rrs2 = $urandom_range(0, 31);
          if ($urandom_range(0, 4) == 0) rimm = $urandom;
          else case (rk)
            3: rimm = (int'($urandom_range(0, 4095)) - 2048) * 2;
            4: rimm = (rf3 == 1 || rf3 == 5) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 4095)) - 2048;
            5: rimm = $urandom & 32'hFFFFF000;
            6: rimm = (int'($urandom_range(0, (1 << 20) - 1)) - (1 << 19)) * 2;
            2: rimm = $urandom;
            default: rimm = int'($urandom_range(0, 4095)) - 2048;
          endcase
          drive(rk, rf3, rf7, rrd, rrs1, rrs2, rimm);
          req.in_valid = ($urandom_range(0, 3) != 0);
        end
        mem.mem_ready = ($urandom_range(0, 9) < 7);
      end
      #1;
      checks++; if (req.in_ready !== (!mem.mem_we || mem.mem_ready)) begin
        errors++; $display("FAIL rnd_ready c=%0d got=%b we=%b mready=%b", c, req.in_ready, mem.mem_we, mem.mem_ready); end
      checks++; if (mem.mem_we !== (q.size() != 0)) begin
        errors++; $display("FAIL rnd_we c=%0d got=%b exp=%b", c, mem.mem_we, q.size() != 0); end
      checks++; if (err !== prev_bad) begin
        errors++; $display("FAIL rnd_err c=%0d got=%b exp=%b", c, err, prev_bad); end
      acc  = req.in_valid && req.in_ready;
      done = mem.mem_we && mem.mem_ready;
      if (done && q.size() != 0) begin
        got = q.pop_front();
        checks++; if (mem.mem_wdata !== got || mem.mem_addr !== exp_addr) begin
          errors++; $display("FAIL rnd_write c=%0d got word=%h addr=%h exp word=%h addr=%h", c, mem.mem_wdata, mem.mem_addr, got, exp_addr); end
        exp_addr += 4;
        exp_wc++;
      end
      prev_bad = 1'b0;
      if (acc) begin
        model(rk, rf3, rf7, rrd, rrs1, rrs2, rimm, w, bad);
        if (bad) begin
          prev_bad = 1'b1;
          if (exp_ec < 255) exp_ec++;
        end else begin
          q.push_back(w);
        end
      end
      step();
    end
    checks++; if (word_count !== 16'(exp_wc) || err_count !== 8'(exp_ec) || mem.mem_addr !== exp_addr) begin
      errors++; $display("FAIL rnd_totals got words=%0d errs=%0d addr=%h exp %0d %0d %h", word_count, err_count, mem.mem_addr, exp_wc, exp_ec, exp_addr); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_jal_lui();
    test_stall();
    test_illegal();
    test_err_saturate();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
